receiver_fsm: RTL and testbench

//  UART receive state machine. Clocked by the 16x-oversampling baud tick from the baud

---
 rtl/receiver_fsm_if.sv | 11 +
 rtl/receiver_fsm.sv | 137 +++++++++++++
 tb/tb_receiver_fsm.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/receiver_fsm_if.sv
// Serial receive bundle: the line into the receiver and the decoded {parity,data} word out.
interface receiver_fsm_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 serialInput;
  logic [DATA_BITS:0]   dataParityOut;
  logic                 ready;

  modport master (output serialInput, input dataParityOut, input ready);
  modport slave  (input serialInput, output dataParityOut, output ready);
endinterface

// File: rtl/receiver_fsm.sv
// UART receive FSM on the 16x oversampling tick: start detect, mid-bit sampling, {parity,data} + ready strobe.
// Optional odd-parity checking is enabled by defining PARITY_CHECK_EN.
module receiver_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic           baudRateOut,
  input  logic           rst,
  receiver_fsm_if.slave  rx
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [DATA_BITS:0]     dout_q, dout_d;
  logic                   ready_q, ready_d;
  logic                   sync1_q, sync2_q;
  logic                   line;
  logic                   frame_ok;

  assign line = sync2_q;

`ifdef PARITY_CHECK_EN
  // Odd parity: data ones plus the parity bit must be odd.
  assign frame_ok = ^{par_q, shift_q};
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge baudRateOut) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      sync1_q <= rx.serialInput;
      sync2_q <= sync1_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
    end
  end

  // Shift register and parity capture only matter once a frame completes, so they carry no reset.
  always_ff @(posedge baudRateOut) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + TICK_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    dout_d  = dout_q;
    ready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (!line) state_d = S_START;
      end
      S_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d = '0;
          bit_d  = '0;
          state_d = line ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          shift_d[bit_q] = line;
          if (bit_q == BIT_LAST) state_d = S_PARITY;
          else                   bit_d   = bit_q + BIT_W'(1);
        end
      end
      S_PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          par_d   = line;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (line) begin
            state_d = S_IDLE;
            if (frame_ok) begin
              dout_d  = {par_q, shift_q};
              ready_d = 1'b1;
            end
          end else begin
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        tick_d = '0;
        if (line) state_d = S_IDLE;
      end
      default: begin
        tick_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx.dataParityOut = dout_q;
  assign rx.ready         = ready_q;

endmodule

// File: tb/tb_receiver_fsm.sv
// Directed bench for receiver_fsm: reset, good frames, glitch, parity, framing break, back-to-back, mid-frame reset.
module tb_receiver_fsm;

  logic clk;
  logic rst;
  int   cyc;
  int   rdy_cnt;
  int   rdy_cyc;
  int   start_cyc;
  int   exp_cnt;
  int   errors;
  int   checks;

  receiver_fsm_if #(.DATA_BITS(8)) rx_if ();

  receiver_fsm #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .baudRateOut (clk),
    .rst         (rst),
    .rx          (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Ready is sampled on the falling edge, half a clock after it was registered.
  always @(negedge clk) begin
    if (rx_if.ready === 1'b1) begin
      rdy_cnt++;
      rdy_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    @(negedge clk);
    rx_if.serialInput = b;
    repeat (n - 1) @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
    @(negedge clk);
    rx_if.serialInput = 1'b0;
    start_cyc = cyc;
    repeat (15) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
    drive_bit(p, 16);
    drive_bit(stp, 16);
  endtask

  initial begin
    cyc = 0; rdy_cnt = 0; rdy_cyc = 0; start_cyc = 0;
    exp_cnt = 0; errors = 0; checks = 0;
    rst = 1'b1;
    rx_if.serialInput = 1'b1;

    // Reset for two clocks with the line idle.
    repeat (2) @(negedge clk);
    #1;
    check("reset_dout", 32'(rx_if.dataParityOut), 32'h000);
    check("reset_ready", 32'(rx_if.ready), 32'd0);
    rst = 1'b0;
    idle(20);
    check("idle_no_ready", rdy_cnt, 0);
    check("idle_dout", 32'(rx_if.dataParityOut), 32'h000);

    // Good frame 0x55, parity 1.
    send_frame(8'h55, 1'b1, 1'b1);
    idle(4);
    exp_cnt = 1;
    check("f155_ready_once", rdy_cnt, exp_cnt);
    check("f155_dout", 32'(rx_if.dataParityOut), 32'h155);
    check("f155_latency", rdy_cyc - start_cyc - 1, 170);

    // Four-clock glitch is rejected.
    drive_bit(1'b0, 4);
    idle(30);
    check("glitch_no_ready", rdy_cnt, exp_cnt);
    check("glitch_dout", 32'(rx_if.dataParityOut), 32'h155);

    // Frame 0x55 with even parity.
    send_frame(8'h55, 1'b0, 1'b1);
    idle(4);
`ifdef PARITY_CHECK_EN
    check("par0_ready", rdy_cnt, exp_cnt);
    check("par0_dout", 32'(rx_if.dataParityOut), 32'h155);
`else
    exp_cnt++;
    check("par0_ready", rdy_cnt, exp_cnt);
    check("par0_dout", 32'(rx_if.dataParityOut), 32'h055);
`endif

    // Framing error: stop bit low, line held low in BREAK.
    send_frame(8'hA3, 1'b1, 1'b0);
    drive_bit(1'b0, 40);
    check("break_no_ready", rdy_cnt, exp_cnt);
    check("break_dout_hold", 32'(rx_if.dataParityOut), (exp_cnt == 1) ? 32'h155 : 32'h055);
    idle(4);
    check("break_release_no_ready", rdy_cnt, exp_cnt);

    // Recovery frame 0x0F parity 1, then an immediate back-to-back 0x81 parity 1.
    send_frame(8'h0F, 1'b1, 1'b1);
    exp_cnt++;
    check("f10f_dout", 32'(rx_if.dataParityOut), 32'h10F);
    check("f10f_latency", rdy_cyc - start_cyc - 1, 170);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(4);
    exp_cnt++;
    check("b2b_ready_count", rdy_cnt, exp_cnt);
    check("b2b_dout", 32'(rx_if.dataParityOut), 32'h181);
    check("b2b_latency", rdy_cyc - start_cyc - 1, 170);

    // Reset during data bit 4.
    @(negedge clk);
    rx_if.serialInput = 1'b0;
    repeat (15) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1, 16);
    drive_bit(1'b1, 8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midrst_dout", 32'(rx_if.dataParityOut), 32'h000);
    check("midrst_ready", 32'(rx_if.ready), 32'd0);
    rst = 1'b0;
    idle(24);
    check("midrst_no_ready", rdy_cnt, exp_cnt);
    check("midrst_dout_hold", 32'(rx_if.dataParityOut), 32'h000);
    send_frame(8'h55, 1'b1, 1'b1);
    idle(4);
    exp_cnt++;
    check("post_rst_ready", rdy_cnt, exp_cnt);
    check("post_rst_dout", 32'(rx_if.dataParityOut), 32'h155);
    check("post_rst_latency", rdy_cyc - start_cyc - 1, 170);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
